w_stage_mc: RTL and testbench
=============================

# w_stage_mc

Multi-channel writeback stage for the core's register-file write port. Accepts completed results from `N_CH` producer channels (ALU, load, mul/div, …), each behind a valid/ready handshake with a one-entry holding register. A round-robin arbiter serialises the held results onto a single registered RF write port. Writes to x0 and writes with `wr_en`=0 are filtered. Optional bypass lookup exposes pending results to the decode stage.

## Interface
Parameters:
- `N_CH`, 2, number of producer channels (≥1)
- `DATA_W`, `N_BITS`, result width
- `ADDR_W`, 5, RF address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  `N_CH`  per-channel result valid
- `in_ready`  out  `N_CH`  per-channel accept
- `in_ctrl`  in  `N_CH` x `rf_wb_ctrl_t`  per-channel {`wr_en`, `rd_addr`[`ADDR_W`-1:0]}
- `in_data`  in  `N_CH` x `DATA_W`  per-channel result
- `rf_we`  out  1  RF write enable (registered)
- `rf_waddr`  out  `ADDR_W`  RF write address (registered)
- `rf_wdata`  out  `DATA_W`  RF write data (registered)
- `busy`  out  1  any holding register or output register valid
- `byp_addr`  in  `ADDR_W`  bypass lookup address (`W_STAGE_MC_BYPASS_EN` only)
- `byp_hit`  out  1  pending write to `byp_addr` exists (`W_STAGE_MC_BYPASS_EN` only)
- `byp_data`  out  `DATA_W`  data of youngest matching pending write (`W_STAGE_MC_BYPASS_EN` only)

## Operation
- Per channel c, a holding register `hold[c]` = {valid, addr, data}.
- `in_ready[c]` = !`hold[c]`.valid | `grant[c]`. It is 0 while `rst` is high.
- Accept occurs on `in_valid[c]` & `in_ready[c]`:
  - If `wr_en` & `rd_addr`≠0, `hold[c]` is loaded.
  - Otherwise the result is consumed and dropped. `hold[c]`.valid clears if it was granted this cycle.
- Arbiter: round-robin over valid holding registers.
  - Search starts at `last_grant`+1 mod `N_CH`.
  - Exactly one grant per cycle when any entry is valid.
  - The granted entry is copied to the output register at the next edge, and its valid bit clears unless it is reloaded by a simultaneous accept.
- Output register: `rf_we`=1 for exactly one cycle per granted entry; `rf_we`=0 in any cycle with no grant.
- Ordering requirement on upstream: no two in-flight writes to the same `rd_addr` across different channels. This is the hazard unit's responsibility. Within a channel, order is preserved.
- `last_grant` updates only on a grant.

## Timing
- Reset values:
  - `hold[*]`.valid=0
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0
  - `last_grant`=`N_CH`-1, so channel 0 has first priority
  - `busy`=0, `byp_hit`=0, `byp_data`=0
- Latency: accept at edge k → `rf_we` high in the cycle following edge k+1, i.e. 2 cycles input-to-write when uncontended.
- Throughput: 1 RF write per cycle aggregate. A single channel sustains 1 result/cycle when uncontended, via the grant-and-reload path.
- Contention: with all `N_CH` channels streaming, each channel receives 1 grant per `N_CH` cycles. `in_ready` deasserts on non-granted full channels.
- Reset mid-operation: all held and output entries are discarded, with no RF write, and the arbiter pointer reinitialises.
- Bypass is combinational over `hold[*]` and the output register.
  - A hold entry wins over the output register, since it is younger.
  - `byp_addr`=0 → `byp_hit`=0, `byp_data`=0.

## Configuration
- `W_STAGE_MC_BYPASS_EN` defined: the `byp_addr`/`byp_hit`/`byp_data` ports and lookup logic are present.
- Not defined: those ports and the lookup logic are absent. Decode stalls on pending writes instead, using `busy` plus the hazard unit's scoreboard.

## Structure
- Shared package `core_types_pkg`:
  - `rf_wb_ctrl_t` (existing)
  - new `wb_entry_t` {valid, `rf_wb_ctrl_t` ctrl, data[`N_BITS`-1:0]}
  - constant `RF_ZERO_ADDR`=0
- Sub-module `rr_arbiter`: parameter `N`; inputs `req`[`N`], `advance`; output one-hot `grant`[`N`]; internal pointer register. It is reused by other arbitration points.
- Holding and output registers use the team's enable/reset register primitive with a synchronous active-high reset.

## Test plan
- Single channel, `N_CH`=2: ch0 sends {rd=5, data=0xDEADBEEF} at cycle 1 → `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF in cycle 3. No other writes occur.
- Filter: ch1 sends rd=0, then `wr_en`=0 with rd=7 → both accepted (`in_ready`=1), `rf_we` never asserts, `busy` stays 0.
- Contention, `N_CH`=3: all channels hold valid entries (rd=1,2,3) from the same cycle → writes in order rd=1,2,3 on consecutive cycles. A fresh ch0 entry is written after ch2.
- Back-pressure: ch0 and ch1 stream continuously for 10 cycles → writes alternate ch0/ch1. Each channel's `in_ready` is 1 every other cycle, and no result is lost or duplicated.
- Reset mid-op: assert `rst` for 1 cycle while two entries are held → no `rf_we` afterwards, `busy`=0, and the next request on ch0 wins first.
- Bypass (macro defined): ch0 holds rd=9/0x11 and the output register holds rd=9/0x22 → `byp_addr`=9 gives `byp_hit`=1, `byp_data`=0x11. `byp_addr`=0 gives `byp_hit`=0.

Source files
------------

// File: rtl/core_types_pkg.sv
// core_types_pkg: shared core types for the RF writeback path
package core_types_pkg;
  localparam int N_BITS = 32;
  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;
  typedef struct packed {
    logic                 wr_en;
    logic [RF_ADDR_W-1:0] rd_addr;
  } rf_wb_ctrl_t;
  typedef struct packed {
    logic              valid;
    rf_wb_ctrl_t       ctrl;
    logic [N_BITS-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/dff_en_rst.sv
// dff_en_rst: enable register with synchronous active-high reset to zero
module dff_en_rst #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin arbiter, search starts after the last grant
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, sel;
  logic found;
  function automatic logic [PW-1:0] wrap(input int k);
    return PW'(k % N);
  endfunction
  always_comb begin
    grant = '0;
    sel = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(ptr) + 1 + i)]) begin
        grant[wrap(int'(ptr) + 1 + i)] = 1'b1;
        sel = wrap(int'(ptr) + 1 + i);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= PW'(N - 1);
    else if (advance && found) ptr <= sel;
endmodule

// File: rtl/w_stage_mc.sv
// w_stage_mc: multi-channel RF writeback stage; bypass lookup under W_STAGE_MC_BYPASS_EN
module w_stage_mc
  import core_types_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DATA_W = N_BITS,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               in_valid,
  output logic [N_CH-1:0]               in_ready,
  input  rf_wb_ctrl_t [N_CH-1:0]        in_ctrl,
  input  logic [N_CH-1:0][DATA_W-1:0]   in_data,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          busy
`ifdef W_STAGE_MC_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]             byp_addr,
  output logic                          byp_hit,
  output logic [DATA_W-1:0]             byp_data
`endif
);
  wb_entry_t [N_CH-1:0] hold, hold_d;
  wb_entry_t out_q, out_d, gsel;
  logic [N_CH-1:0] req, grant, load, hold_en;
  always_comb
    for (int c = 0; c < N_CH; c++) req[c] = hold[c].valid;
  rr_arbiter #(.N(N_CH)) u_arb (
    .clk(clk), .rst(rst), .req(req), .advance(|req), .grant(grant)
  );
  // a granted slot can take a new result in the same cycle it drains
  always_comb begin
    in_ready = '0;
    load = '0;
    hold_en = '0;
    hold_d = '0;
    gsel = '0;
    for (int c = 0; c < N_CH; c++) begin
      in_ready[c] = !rst && (!hold[c].valid || grant[c]);
      load[c] = in_valid[c] && in_ready[c] && in_ctrl[c].wr_en && in_ctrl[c].rd_addr != RF_ZERO_ADDR;
      hold_en[c] = load[c] || grant[c];
      hold_d[c] = load[c] ? wb_entry_t'{valid: 1'b1, ctrl: in_ctrl[c], data: in_data[c]} : wb_entry_t'('0);
      if (grant[c]) gsel = hold[c];
    end
    out_d = |grant ? gsel : wb_entry_t'{valid: 1'b0, ctrl: out_q.ctrl, data: out_q.data};
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_hold
    dff_en_rst #(.W($bits(wb_entry_t))) u_hold (
      .clk(clk), .rst(rst), .en(hold_en[c]), .d(hold_d[c]), .q(hold[c])
    );
  end
  dff_en_rst #(.W($bits(wb_entry_t))) u_out (
    .clk(clk), .rst(rst), .en(1'b1), .d(out_d), .q(out_q)
  );
  assign rf_we = out_q.valid;
  assign rf_waddr = out_q.ctrl.rd_addr;
  assign rf_wdata = out_q.data;
  assign busy = |req || out_q.valid;
`ifdef W_STAGE_MC_BYPASS_EN
  // holds are younger than the output register, so they are checked last and win
  always_comb begin
    byp_hit = 1'b0;
    byp_data = '0;
    if (byp_addr != RF_ZERO_ADDR) begin
      if (out_q.valid && out_q.ctrl.rd_addr == byp_addr) begin
        byp_hit = 1'b1;
        byp_data = out_q.data;
      end
      for (int c = 0; c < N_CH; c++)
        if (hold[c].valid && hold[c].ctrl.rd_addr == byp_addr) begin
          byp_hit = 1'b1;
          byp_data = hold[c].data;
        end
    end
  end
`endif
endmodule

// File: tb/tb_w_stage_mc.sv
// tb_w_stage_mc: directed self-checking bench for w_stage_mc (2- and 3-channel instances)
module tb_w_stage_mc;
  import core_types_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] a_valid, a_ready;
  rf_wb_ctrl_t [1:0] a_ctrl;
  logic [1:0][31:0] a_data;
  logic a_we, a_busy;
  logic [4:0] a_waddr;
  logic [31:0] a_wdata;
  logic [2:0] b_valid, b_ready;
  rf_wb_ctrl_t [2:0] b_ctrl;
  logic [2:0][31:0] b_data;
  logic b_we, b_busy;
  logic [4:0] b_waddr;
  logic [31:0] b_wdata;
`ifdef W_STAGE_MC_BYPASS_EN
  logic [4:0] a_byp_addr, b_byp_addr;
  logic a_byp_hit, b_byp_hit;
  logic [31:0] a_byp_data, b_byp_data;
`endif
  w_stage_mc #(.N_CH(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_ctrl(a_ctrl),
    .in_data(a_data), .rf_we(a_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata), .busy(a_busy)
`ifdef W_STAGE_MC_BYPASS_EN
    , .byp_addr(a_byp_addr), .byp_hit(a_byp_hit), .byp_data(a_byp_data)
`endif
  );
  w_stage_mc #(.N_CH(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_ctrl(b_ctrl),
    .in_data(b_data), .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata), .busy(b_busy)
`ifdef W_STAGE_MC_BYPASS_EN
    , .byp_addr(b_byp_addr), .byp_hit(b_byp_hit), .byp_data(b_byp_data)
`endif
  );
  int n_chk = 0;
  int n_err = 0;
  int a_wr_cnt = 0;
  logic [31:0] a_wq[$];
  always @(negedge clk)
    if (a_we === 1'b1) begin
      a_wr_cnt++;
      a_wq.push_back(a_wdata);
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  int snap, na, nb;
  logic [1:0] exp_r;
  initial begin
    a_valid = '0; a_ctrl = '0; a_data = '0;
    b_valid = '0; b_ctrl = '0; b_data = '0;
`ifdef W_STAGE_MC_BYPASS_EN
    a_byp_addr = '0; b_byp_addr = '0;
`endif
    cyc(); cyc();
    chk("rst_ready_a", a_ready, 2'b00);
    chk("rst_ready_b", b_ready, 3'b000);
    chk("rst_we", a_we, 1'b0);
    chk("rst_waddr", a_waddr, 5'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_busy_b", b_busy, 1'b0);
`ifdef W_STAGE_MC_BYPASS_EN
    chk("rst_byp_hit", a_byp_hit, 1'b0);
    chk("rst_byp_data", a_byp_data, 32'd0);
`endif
    rst = 1'b0;
    // single write, 2-cycle latency
    snap = a_wr_cnt;
    a_valid = 2'b01; a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd5}; a_data[0] = 32'hDEADBEEF;
    #1 chk("single_ready", a_ready, 2'b11);
    cyc();
    a_valid = '0;
    chk("single_we_c2", a_we, 1'b0);
    chk("single_busy_c2", a_busy, 1'b1);
    cyc();
    chk("single_we_c3", a_we, 1'b1);
    chk("single_waddr", a_waddr, 5'd5);
    chk("single_wdata", a_wdata, 32'hDEADBEEF);
    cyc();
    chk("single_we_c4", a_we, 1'b0);
    chk("single_busy_c4", a_busy, 1'b0);
    chk("single_count", a_wr_cnt - snap, 1);
    // filtered writes: rd=0, then wr_en=0
    snap = a_wr_cnt;
    a_valid = 2'b10; a_ctrl[1] = '{wr_en: 1'b1, rd_addr: 5'd0}; a_data[1] = 32'h12345678;
    #1 chk("filt0_ready", a_ready[1], 1'b1);
    cyc();
    chk("filt0_busy", a_busy, 1'b0);
    a_ctrl[1] = '{wr_en: 1'b0, rd_addr: 5'd7};
    #1 chk("filt7_ready", a_ready[1], 1'b1);
    cyc();
    a_valid = '0;
    chk("filt7_busy", a_busy, 1'b0);
    cyc(); cyc();
    chk("filt_busy_end", a_busy, 1'b0);
    chk("filt_count", a_wr_cnt - snap, 0);
    // both channels streaming: grants alternate, ch1 first since ch0 was granted last
    a_wq.delete();
    na = 0; nb = 0;
    for (int k = 0; k < 10; k++) begin
      a_valid = 2'b11;
      a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd10}; a_data[0] = 32'h100 + 32'(na);
      a_ctrl[1] = '{wr_en: 1'b1, rd_addr: 5'd11}; a_data[1] = 32'h200 + 32'(nb);
      #1;
      exp_r = k == 0 ? 2'b11 : (k % 2 == 1 ? 2'b10 : 2'b01);
      chk($sformatf("bp_ready%0d", k), a_ready, exp_r);
      if (a_ready[0]) na++;
      if (a_ready[1]) nb++;
      cyc();
    end
    a_valid = '0;
    cyc(); cyc(); cyc(); cyc();
    chk("bp_sent_a", na, 5);
    chk("bp_sent_b", nb, 6);
    chk("bp_nwrites", a_wq.size(), 11);
    for (int i = 0; i < a_wq.size() && i < 11; i++)
      chk($sformatf("bp_w%0d", i), a_wq[i], (i % 2 == 1) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2));
    chk("bp_busy_end", a_busy, 1'b0);
    // reset with two held entries
    a_valid = 2'b11;
    a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd3}; a_data[0] = 32'h30;
    a_ctrl[1] = '{wr_en: 1'b1, rd_addr: 5'd4}; a_data[1] = 32'h40;
    #1 chk("rm_ready0", a_ready, 2'b11);
    cyc();
    a_valid = 2'b01; a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd5}; a_data[0] = 32'h50;
    #1 chk("rm_ready1", a_ready, 2'b01);
    cyc();
    a_valid = '0; rst = 1'b1;
    #1 chk("rm_ready_rst", a_ready, 2'b00);
    chk("rm_busy_pre", a_busy, 1'b1);
    cyc();
    rst = 1'b0;
    snap = a_wr_cnt;
    chk("rm_we", a_we, 1'b0);
    chk("rm_busy", a_busy, 1'b0);
    chk("rm_waddr", a_waddr, 5'd0);
    cyc(); cyc();
    chk("rm_count", a_wr_cnt - snap, 0);
    a_valid = 2'b11;
    a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd6}; a_data[0] = 32'h60;
    a_ctrl[1] = '{wr_en: 1'b1, rd_addr: 5'd7}; a_data[1] = 32'h70;
    cyc();
    a_valid = '0;
    cyc();
    chk("rm_first_we", a_we, 1'b1);
    chk("rm_first_addr", a_waddr, 5'd6);
    chk("rm_first_data", a_wdata, 32'h60);
    cyc();
    chk("rm_second_addr", a_waddr, 5'd7);
    cyc();
    chk("rm_idle_we", a_we, 1'b0);
    // 3-channel contention, fresh ch0 entry follows ch2
    b_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      b_ctrl[c] = '{wr_en: 1'b1, rd_addr: 5'(c + 1)};
      b_data[c] = 32'(c + 1);
    end
    cyc();
    b_valid = 3'b001; b_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd4}; b_data[0] = 32'h4;
    #1 chk("ct_ready", b_ready, 3'b001);
    cyc();
    b_valid = '0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ct_we%0d", i), b_we, 1'b1);
      chk($sformatf("ct_addr%0d", i), b_waddr, 5'(i));
      chk($sformatf("ct_data%0d", i), b_wdata, 32'(i));
      cyc();
    end
    chk("ct_idle_we", b_we, 1'b0);
    chk("ct_idle_busy", b_busy, 1'b0);
`ifdef W_STAGE_MC_BYPASS_EN
    // ch0 holds rd9/0x11 while the output register holds rd9/0x22
    a_valid = 2'b01; a_ctrl[0] = '{wr_en: 1'b1, rd_addr: 5'd9}; a_data[0] = 32'h22;
    cyc();
    a_data[0] = 32'h11;
    #1 chk("byp_ready", a_ready[0], 1'b1);
    cyc();
    a_valid = '0; a_byp_addr = 5'd9;
    #1 chk("byp_hit9", a_byp_hit, 1'b1);
    chk("byp_data9", a_byp_data, 32'h11);
    chk("byp_out_data", a_wdata, 32'h22);
    a_byp_addr = 5'd0;
    #1 chk("byp_hit0", a_byp_hit, 1'b0);
    chk("byp_data0", a_byp_data, 32'd0);
    a_byp_addr = 5'd12;
    #1 chk("byp_miss", a_byp_hit, 1'b0);
    cyc();
    a_byp_addr = 5'd9;
    #1 chk("byp_out_hit", a_byp_hit, 1'b1);
    chk("byp_out_hdata", a_byp_data, 32'h11);
    cyc();
    chk("byp_gone", a_byp_hit, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
